axis_loopback_fifo: RTL and testbench

AXIS_LOOPBACK_FIFO -- requirements
Module: axis_loopback_fifo

---
 rtl/axis_loopback_fifo.sv | 147 ++++++++++++++
 tb/tb_axis_loopback_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_loopback_fifo.sv
// -----------------------------------------------------------------------------
// axis_loopback_fifo
//   AXI-Stream loopback through a first-word fall-through FIFO. Beats accepted
//   on the H2C side are optionally byte-reversed and stored with their tkeep
//   and tlast. They are then replayed in order on the C2H side. The block also
//   reports FIFO occupancy and counts completed egress packets.
//
// Ports
//   AXI_clock, AXI_reset_n  : clock, asynchronous active-low reset
//   AXIS_H2C_*              : ingress stream (tdata/tkeep/tlast/tvalid/tready)
//   AXIS_C2H_*              : egress stream  (tdata/tkeep/tlast/tvalid/tready)
//   cfg_enable              : gates ingress acceptance
//   cfg_swap                : byte-reverse tdata/tkeep of beats being pushed
//   stat_clear              : synchronous clear of stat_pkt_count
//   stat_level              : current FIFO occupancy in beats
//   stat_pkt_count          : number of egress beats popped with tlast set
// -----------------------------------------------------------------------------
module axis_loopback_fifo #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned CNT_W  = 32,
   parameter int unsigned KEEP_W = DATA_W / 8,
   parameter int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
   input  logic              AXI_clock,
   input  logic              AXI_reset_n,

   input  logic [DATA_W-1:0] AXIS_H2C_tdata,
   input  logic [KEEP_W-1:0] AXIS_H2C_tkeep,
   input  logic              AXIS_H2C_tlast,
   input  logic              AXIS_H2C_tvalid,
   output logic              AXIS_H2C_tready,

   output logic [DATA_W-1:0] AXIS_C2H_tdata,
   output logic [KEEP_W-1:0] AXIS_C2H_tkeep,
   output logic              AXIS_C2H_tlast,
   output logic              AXIS_C2H_tvalid,
   input  logic              AXIS_C2H_tready,

   input  logic              cfg_enable,
   input  logic              cfg_swap,
   input  logic              stat_clear,
   output logic [LVL_W-1:0]  stat_level,
   output logic [CNT_W-1:0]  stat_pkt_count
);

   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned ENTRY_W = DATA_W + KEEP_W + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

   logic [ENTRY_W-1:0] mem_q [DEPTH];

   logic               push, pop;
   logic [DATA_W-1:0]  in_data;
   logic [KEEP_W-1:0]  in_keep;
   logic [ENTRY_W-1:0] head;

   // ---------------------------------------------------------------------------
   // Handshakes. tready only looks at local state, never at C2H tready.
   // Reset is folded in so tready is low for as long as reset is held.
   // ---------------------------------------------------------------------------
   always_comb begin
      AXIS_H2C_tready = AXI_reset_n & cfg_enable & (level_q != FULL_LVL);
      AXIS_C2H_tvalid = (level_q != '0);
      push            = AXIS_H2C_tvalid & AXIS_H2C_tready;
      pop             = AXIS_C2H_tvalid & AXIS_C2H_tready;
   end

   // ---------------------------------------------------------------------------
   // Ingress byte reversal. Applied at push time, so later cfg_swap changes
   // leave stored beats untouched.
   // ---------------------------------------------------------------------------
   always_comb begin
      in_data = AXIS_H2C_tdata;
      in_keep = AXIS_H2C_tkeep;
      if (cfg_swap) begin
         for (int unsigned i = 0; i < KEEP_W; i++) begin
            in_data[8*(KEEP_W-1-i) +: 8] = AXIS_H2C_tdata[8*i +: 8];
            in_keep[KEEP_W-1-i]          = AXIS_H2C_tkeep[i];
         end
      end
   end

   // Storage has no reset; validity is tracked entirely by level_q.
   always_ff @(posedge AXI_clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {in_data, in_keep, AXIS_H2C_tlast};
      end
   end

   // ---------------------------------------------------------------------------
   // Pointer, level and packet counter next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      pkt_cnt_d = pkt_cnt_q;

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      unique case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase

      // Clear wins over a coincident counted pop.
      if (stat_clear) begin
         pkt_cnt_d = '0;
      end else if (pop && head[0]) begin
         pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge AXI_clock or negedge AXI_reset_n) begin
      if (!AXI_reset_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         pkt_cnt_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Egress: oldest entry, zeroed while empty so reset and an empty FIFO
   // never expose stale storage.
   // ---------------------------------------------------------------------------
   always_comb begin
      head = AXIS_C2H_tvalid ? mem_q[rd_ptr_q] : '0;
      {AXIS_C2H_tdata, AXIS_C2H_tkeep, AXIS_C2H_tlast} = head;
      stat_level     = level_q;
      stat_pkt_count = pkt_cnt_q;
   end

endmodule

// File: tb/tb_axis_loopback_fifo.sv
module tb_axis_loopback_fifo;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned KEEP_W = DATA_W / 8;
   localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;

   logic              clk;
   logic              rst_n;
   logic [DATA_W-1:0] h2c_tdata;
   logic [KEEP_W-1:0] h2c_tkeep;
   logic              h2c_tlast;
   logic              h2c_tvalid;
   logic              h2c_tready;
   logic [DATA_W-1:0] c2h_tdata;
   logic [KEEP_W-1:0] c2h_tkeep;
   logic              c2h_tlast;
   logic              c2h_tvalid;
   logic              c2h_tready;
   logic              cfg_enable;
   logic              cfg_swap;
   logic              stat_clear;
   logic [LVL_W-1:0]  stat_level;
   logic [CNT_W-1:0]  stat_pkt_count;

   int checks = 0;
   int errors = 0;

   axis_loopback_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) dut (
      .AXI_clock       (clk),
      .AXI_reset_n     (rst_n),
      .AXIS_H2C_tdata  (h2c_tdata),
      .AXIS_H2C_tkeep  (h2c_tkeep),
      .AXIS_H2C_tlast  (h2c_tlast),
      .AXIS_H2C_tvalid (h2c_tvalid),
      .AXIS_H2C_tready (h2c_tready),
      .AXIS_C2H_tdata  (c2h_tdata),
      .AXIS_C2H_tkeep  (c2h_tkeep),
      .AXIS_C2H_tlast  (c2h_tlast),
      .AXIS_C2H_tvalid (c2h_tvalid),
      .AXIS_C2H_tready (c2h_tready),
      .cfg_enable      (cfg_enable),
      .cfg_swap        (cfg_swap),
      .stat_clear      (stat_clear),
      .stat_level      (stat_level),
      .stat_pkt_count  (stat_pkt_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n      = 1'b0;
      h2c_tdata  = '0;
      h2c_tkeep  = '0;
      h2c_tlast  = 1'b0;
      h2c_tvalid = 1'b0;
      c2h_tready = 1'b0;
      cfg_enable = 1'b1;
      cfg_swap   = 1'b0;
      stat_clear = 1'b0;

      // Reset state
      #2;
      chk("rst_tvalid", 64'(c2h_tvalid), 64'd0);
      chk("rst_tready", 64'(h2c_tready), 64'd0);
      chk("rst_level",  64'(stat_level), 64'd0);
      chk("rst_pkt",    64'(stat_pkt_count), 64'd0);
      chk("rst_tdata",  c2h_tdata, 64'd0);
      tick();
      tick();
      #2 rst_n = 1'b1;
      tick();
      chk("post_rst_tready", 64'(h2c_tready), 64'd1);

      // Single beat, one-cycle latency
      c2h_tready = 1'b1;
      h2c_tvalid = 1'b1;
      h2c_tdata  = 64'h0011223344556677;
      h2c_tkeep  = 8'hFF;
      h2c_tlast  = 1'b1;
      tick();
      h2c_tvalid = 1'b0;
      chk("single_tvalid", 64'(c2h_tvalid), 64'd1);
      chk("single_tdata",  c2h_tdata, 64'h0011223344556677);
      chk("single_tkeep",  64'(c2h_tkeep), 64'hFF);
      chk("single_tlast",  64'(c2h_tlast), 64'd1);
      chk("single_level",  64'(stat_level), 64'd1);
      tick();
      chk("single_pkt",    64'(stat_pkt_count), 64'd1);
      chk("single_empty",  64'(c2h_tvalid), 64'd0);

      // Fill under backpressure: 20 offered, 16 accepted
      c2h_tready = 1'b0;
      h2c_tlast  = 1'b0;
      h2c_tvalid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         h2c_tdata = 64'(i);
         tick();
      end
      h2c_tvalid = 1'b0;
      chk("full_level",  64'(stat_level), 64'd16);
      chk("full_tready", 64'(h2c_tready), 64'd0);
      tick();
      chk("hold_tdata",  c2h_tdata, 64'd0);
      chk("hold_level",  64'(stat_level), 64'd16);
      c2h_tready = 1'b1;
      #1;
      for (int i = 0; i < 16; i++) begin
         chk("drain_tvalid", 64'(c2h_tvalid), 64'd1);
         chk("drain_tdata",  c2h_tdata, 64'(i));
         tick();
      end
      chk("drain_level", 64'(stat_level), 64'd0);
      chk("drain_pkt",   64'(stat_pkt_count), 64'd1);

      // Swap mode, then flip cfg_swap with the beat already stored
      c2h_tready = 1'b0;
      cfg_swap   = 1'b1;
      h2c_tvalid = 1'b1;
      h2c_tdata  = 64'h0011223344556677;
      h2c_tkeep  = 8'h0F;
      h2c_tlast  = 1'b1;
      tick();
      h2c_tvalid = 1'b0;
      cfg_swap   = 1'b0;
      tick();
      chk("swap_tdata", c2h_tdata, 64'h7766554433221100);
      chk("swap_tkeep", 64'(c2h_tkeep), 64'hF0);
      chk("swap_tlast", 64'(c2h_tlast), 64'd1);
      c2h_tready = 1'b1;
      tick();
      chk("swap_pkt",   64'(stat_pkt_count), 64'd2);

      // Simultaneous push and pop at level 1, then clear vs counted pop
      c2h_tready = 1'b0;
      h2c_tvalid = 1'b1;
      h2c_tdata  = 64'hAA;
      h2c_tkeep  = 8'hFF;
      h2c_tlast  = 1'b0;
      tick();
      chk("sim_level1", 64'(stat_level), 64'd1);
      h2c_tdata  = 64'hBB;
      h2c_tlast  = 1'b1;
      c2h_tready = 1'b1;
      tick();
      h2c_tvalid = 1'b0;
      chk("sim_level",  64'(stat_level), 64'd1);
      chk("sim_tdata",  c2h_tdata, 64'hBB);
      chk("sim_pkt",    64'(stat_pkt_count), 64'd2);
      stat_clear = 1'b1;
      tick();
      stat_clear = 1'b0;
      chk("clr_pkt",    64'(stat_pkt_count), 64'd0);
      chk("clr_level",  64'(stat_level), 64'd0);

      // cfg_enable drops tready immediately
      cfg_enable = 1'b0;
      h2c_tvalid = 1'b1;
      #1;
      chk("dis_tready", 64'(h2c_tready), 64'd0);
      tick();
      chk("dis_level",  64'(stat_level), 64'd0);
      cfg_enable = 1'b1;
      h2c_tvalid = 1'b0;

      // Reset mid-stream at level 5
      c2h_tready = 1'b0;
      h2c_tvalid = 1'b1;
      h2c_tlast  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         h2c_tdata = 64'h100 + 64'(i);
         tick();
      end
      h2c_tvalid = 1'b0;
      chk("mid_level5", 64'(stat_level), 64'd5);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_tvalid", 64'(c2h_tvalid), 64'd0);
      chk("mid_level",  64'(stat_level), 64'd0);
      chk("mid_tready", 64'(h2c_tready), 64'd0);
      chk("mid_tdata",  c2h_tdata, 64'd0);
      #1 rst_n = 1'b1;
      tick();
      h2c_tvalid = 1'b1;
      h2c_tdata  = 64'hCAFE;
      tick();
      h2c_tvalid = 1'b0;
      chk("new_level",  64'(stat_level), 64'd1);
      chk("new_tdata",  c2h_tdata, 64'hCAFE);
      c2h_tready = 1'b1;
      tick();
      chk("new_empty",  64'(c2h_tvalid), 64'd0);
      chk("new_pkt",    64'(stat_pkt_count), 64'd0);

      // Counter wrap: 17 single-beat packets with a 4-bit counter
      h2c_tvalid = 1'b1;
      h2c_tlast  = 1'b1;
      for (int i = 0; i < 17; i++) begin
         h2c_tdata = 64'h200 + 64'(i);
         tick();
      end
      h2c_tvalid = 1'b0;
      tick();
      tick();
      chk("wrap_pkt",   64'(stat_pkt_count), 64'd1);
      chk("wrap_level", 64'(stat_level), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
